// File: rtl/eth_rx_frame_filter_if.sv
// Stream bundle around the receive frame filter.
// Carries the raw MAC receive stream (no backpressure) and the filtered
// AXI-Stream toward the command decoder.
//   slave  : filter view (consumes rx_mac_*, produces rx_axis_*, sees tready)
//   master : environment view (MAC source plus decoder sink)
interface eth_rx_frame_filter_if;
    logic [7:0] rx_mac_tdata;
    logic       rx_mac_tvalid;
    logic       rx_mac_tlast;
    logic       rx_mac_tuser;
    logic [7:0] rx_axis_tdata;
    logic       rx_axis_tvalid;
    logic       rx_axis_tlast;
    logic       rx_axis_tready;

    modport slave (
        input  rx_mac_tdata, rx_mac_tvalid, rx_mac_tlast, rx_mac_tuser,
        input  rx_axis_tready,
        output rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast
    );

    modport master (
        output rx_mac_tdata, rx_mac_tvalid, rx_mac_tlast, rx_mac_tuser,
        output rx_axis_tready,
        input  rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast
    );
endinterface

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward receive frame filter.
// Buffers each MAC frame and releases it to the decoder only if it is good,
// long enough, fitted in the buffer and is addressed to fpga_mac (or broadcast).
// Rejected frames are rolled back by restoring the write pointer to the last
// committed frame boundary.
// Ports:
//   gtx_clk_bufg / gtx_resetn : clock, async active-low reset
//   fpga_mac                  : local MAC, byte 0 in [47:40]
//   bus                       : raw MAC stream in, filtered AXI-Stream out
//   frames_passed/dropped     : wrapping frame counters
//   overflow                  : one-cycle pulse on a frame dropped for space
module eth_rx_frame_filter #(
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter int unsigned MIN_FRAME_LEN = 14
) (
    input  logic                        gtx_clk_bufg,
    input  logic                        gtx_resetn,
    input  logic [47:0]                 fpga_mac,
    eth_rx_frame_filter_if.slave        bus,
    output logic [15:0]                 frames_passed,
    output logic [15:0]                 frames_dropped,
    output logic                        overflow
);
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] ST_SYNC = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_PASS = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    logic [8:0]       mem [DEPTH];

    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             mac_ok_q, mac_ok_d;
    logic             bc_ok_q, bc_ok_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      passed_q, passed_d;
    logic [15:0]      dropped_q, dropped_d;
    logic             overflow_q, overflow_d;

    logic             s1_valid_q;
    logic [8:0]       s1_data_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_last_q;

    logic [PTR_W-1:0] fill_c;
    logic             full_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [2:0]       hdr_idx_c;
    logic [7:0]       mac_byte_c;
    logic             byte_mac_c;
    logic             byte_bc_c;
    logic             we_c;
    logic             accept_c;
    logic             reject_c;
    logic             out_ready_c;
    logic             s1_ready_c;
    logic             rd_en_c;

    // Occupancy uses the pre-update read pointer; MSB set means exactly full.
    assign fill_c    = wr_ptr_q - rd_ptr_q;
    assign full_c    = fill_c[PTR_W-1];
    assign cnt_inc_c = (byte_cnt_q == {CNT_W{1'b1}}) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);

    // Destination byte under test: byte 0 in IDLE, byte_cnt in HDR.
    assign hdr_idx_c = (state_q == ST_IDLE) ? 3'd0 : byte_cnt_q[2:0];
    always_comb begin
        mac_byte_c = fpga_mac[7:0];
        case (hdr_idx_c)
            3'd0:    mac_byte_c = fpga_mac[47:40];
            3'd1:    mac_byte_c = fpga_mac[39:32];
            3'd2:    mac_byte_c = fpga_mac[31:24];
            3'd3:    mac_byte_c = fpga_mac[23:16];
            3'd4:    mac_byte_c = fpga_mac[15:8];
            default: mac_byte_c = fpga_mac[7:0];
        endcase
    end
    assign byte_mac_c = (bus.rx_mac_tdata == mac_byte_c);
    assign byte_bc_c  = (bus.rx_mac_tdata == 8'hFF);

    // Write FSM next-state, commit/rollback and counter logic.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        byte_cnt_d  = byte_cnt_q;
        mac_ok_d    = mac_ok_q;
        bc_ok_d     = bc_ok_q;
        ovf_d       = ovf_q;
        passed_d    = passed_q;
        dropped_d   = dropped_q;
        overflow_d  = 1'b0;
        we_c        = 1'b0;
        accept_c    = 1'b0;
        reject_c    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                // A frame already in flight at reset release is skipped silently.
                if (bus.rx_mac_tvalid && !bus.rx_mac_tlast) state_d = ST_DROP;
                else                                        state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.rx_mac_tvalid) begin
                    we_c       = !full_c;
                    ovf_d      = full_c;
                    byte_cnt_d = CNT_W'(1);
                    mac_ok_d   = byte_mac_c;
                    bc_ok_d    = byte_bc_c;
                    reject_c   = bus.rx_mac_tlast;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (bus.rx_mac_tvalid) begin
                    we_c       = !ovf_q && !full_c;
                    ovf_d      = ovf_q | full_c;
                    byte_cnt_d = cnt_inc_c;
                    mac_ok_d   = mac_ok_q & byte_mac_c;
                    bc_ok_d    = bc_ok_q & byte_bc_c;
                    reject_c   = bus.rx_mac_tlast;
                    if (byte_cnt_q == CNT_W'(5)) state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (bus.rx_mac_tvalid) begin
                    we_c       = !ovf_q && !full_c;
                    ovf_d      = ovf_q | full_c;
                    byte_cnt_d = cnt_inc_c;
                    if (bus.rx_mac_tlast) begin
                        if (!bus.rx_mac_tuser && !ovf_d
                            && (cnt_inc_c >= CNT_W'(MIN_FRAME_LEN))
                            && (mac_ok_q || (ACCEPT_BCAST && bc_ok_q)))
                            accept_c = 1'b1;
                        else
                            reject_c = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (bus.rx_mac_tvalid && bus.rx_mac_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_SYNC;
        endcase

        if (we_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        // Commit includes the tlast byte written this beat.
        if (accept_c) begin
            wr_commit_d = wr_ptr_d;
            passed_d    = passed_q + 16'd1;
            state_d     = ST_IDLE;
        end
        if (reject_c) begin
            wr_ptr_d   = wr_commit_q;
            dropped_d  = dropped_q + 16'd1;
            overflow_d = ovf_d;
            state_d    = ST_IDLE;
        end
    end

    // Write-side state registers.
    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            state_q     <= ST_SYNC;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            byte_cnt_q  <= '0;
            mac_ok_q    <= 1'b0;
            bc_ok_q     <= 1'b0;
            ovf_q       <= 1'b0;
            passed_q    <= '0;
            dropped_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            byte_cnt_q  <= byte_cnt_d;
            mac_ok_q    <= mac_ok_d;
            bc_ok_q     <= bc_ok_d;
            ovf_q       <= ovf_d;
            passed_q    <= passed_d;
            dropped_q   <= dropped_d;
            overflow_q  <= overflow_d;
        end
    end

    // Frame buffer, {tlast, data} per entry.
    always_ff @(posedge gtx_clk_bufg) begin
        if (we_c) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.rx_mac_tlast, bus.rx_mac_tdata};
    end

    // Two-stage read pipeline (RAM read register, output register) that
    // stalls as a unit, so it streams 1 byte/cycle and holds under backpressure.
    assign out_ready_c = !out_valid_q || bus.rx_axis_tready;
    assign s1_ready_c  = !s1_valid_q || out_ready_c;
    assign rd_en_c     = (rd_ptr_q != wr_commit_q) && s1_ready_c;

    always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
        if (!gtx_resetn) begin
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (rd_en_c) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                s1_data_q  <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                s1_valid_q <= 1'b1;
            end else if (out_ready_c) begin
                s1_valid_q <= 1'b0;
            end
            if (out_ready_c) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= s1_data_q[7:0];
                    out_last_q <= s1_data_q[8];
                end
            end
        end
    end

    assign bus.rx_axis_tdata  = out_data_q;
    assign bus.rx_axis_tvalid = out_valid_q;
    assign bus.rx_axis_tlast  = out_last_q;
    assign frames_passed      = passed_q;
    assign frames_dropped     = dropped_q;
    assign overflow           = overflow_q;
endmodule
